// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: merges hazards, redirects, data-memory waits and MDU busy
// windows into stage enables, bubble injects, PC-select and performance counters.
module pipe_hazard_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_load_use,
    input  logic             ex_redirect,
    input  logic [31:0]      ex_redirect_pc,
    input  logic             im_ready,
    input  logic             dm_req,
    input  logic             dm_ready,
    input  logic             mdu_start,
    input  logic             mdu_done,
    output logic             pc_en,
    output logic             pc_sel_redirect,
    output logic [31:0]      pc_redirect,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             fd_bubble,
    output logic             de_bubble,
    output logic             mdu_go,
    output logic             mdu_err,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    // state    | meaning
    // RUN      | normal flow; hazards resolved combinationally
    // MEM_WAIT | frozen until data memory completes
    // MDU_WAIT | frozen until MDU result or timeout
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MDU_WAIT = 2'd2
    } state_t;

    localparam int WAIT_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MDU_TIMEOUT - 1);

    state_t              state, state_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                mem_stall;
    logic                timeout;
    logic                freeze;
    logic                redirect_ok;

    assign mem_stall = dm_req & ~dm_ready;
    assign timeout   = (state == MDU_WAIT) & ~mdu_done & (wait_cnt == WAIT_LAST);

    always_comb begin
        state_next = state;
        freeze     = 1'b0;
        mdu_go     = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    freeze     = 1'b1;
                    state_next = MEM_WAIT;
                end else if (mdu_start) begin
                    freeze     = 1'b1;
                    mdu_go     = 1'b1;
                    state_next = MDU_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dm_ready) state_next = RUN;
                else          freeze     = 1'b1;
            end
            MDU_WAIT: begin
                if (mdu_done || timeout) state_next = RUN;
                else                     freeze     = 1'b1;
            end
            default: state_next = RUN;
        endcase
        if (rst) mdu_go = 1'b0;
    end

    assign redirect_ok = ~rst & ~freeze & ex_redirect;

    always_comb begin
        pc_en           = 1'b0;
        pc_sel_redirect = 1'b0;
        fd_en           = 1'b0;
        de_en           = 1'b0;
        em_en           = 1'b0;
        mw_en           = 1'b0;
        fd_bubble       = 1'b0;
        de_bubble       = 1'b0;
        if (rst) begin
            fd_bubble = 1'b1;
            de_bubble = 1'b1;
        end else if (!freeze) begin
            de_en = 1'b1;
            em_en = 1'b1;
            mw_en = 1'b1;
            if (ex_redirect) begin
                pc_en           = 1'b1;
                pc_sel_redirect = 1'b1;
                fd_en           = 1'b1;
                fd_bubble       = 1'b1;
                de_bubble       = 1'b1;
            end else if (ex_load_use) begin
                de_bubble = 1'b1;
            end else if (!im_ready) begin
                fd_en     = 1'b1;
                fd_bubble = 1'b1;
            end else begin
                pc_en = 1'b1;
                fd_en = 1'b1;
            end
        end
    end

    assign pc_redirect = pc_sel_redirect ? ex_redirect_pc : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mdu_err     <= 1'b0;
            cyc_cnt     <= '0;
            mispred_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            state   <= state_next;
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            // Counter restarts on every entry so a fresh MDU op gets the full window.
            if (state != MDU_WAIT)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (timeout)
                mdu_err <= 1'b1;
            if (redirect_ok)
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            if (!pc_en)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; a narrow-counter second
// instance covers performance-counter wrap.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_load_use, ex_redirect, im_ready, dm_req, dm_ready, mdu_start, mdu_done;
    logic [31:0] ex_redirect_pc;

    logic        pc_en, pc_sel_redirect, fd_en, de_en, em_en, mw_en;
    logic        fd_bubble, de_bubble, mdu_go, mdu_err;
    logic [31:0] pc_redirect, cyc_cnt, mispred_cnt, stall_cnt;

    logic        w_pc_en, w_pc_sel, w_fd_en, w_de_en, w_em_en, w_mw_en;
    logic        w_fd_bub, w_de_bub, w_mdu_go, w_mdu_err;
    logic [31:0] w_pc_redirect;
    logic [3:0]  w_cyc_cnt, w_mispred_cnt, w_stall_cnt;

    int checks = 0;
    int errors = 0;
    int frozen_seen;
    logic [31:0] m0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MDU_TIMEOUT(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .ex_load_use(ex_load_use), .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
        .im_ready(im_ready), .dm_req(dm_req), .dm_ready(dm_ready),
        .mdu_start(mdu_start), .mdu_done(mdu_done),
        .pc_en(pc_en), .pc_sel_redirect(pc_sel_redirect), .pc_redirect(pc_redirect),
        .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
        .fd_bubble(fd_bubble), .de_bubble(de_bubble),
        .mdu_go(mdu_go), .mdu_err(mdu_err),
        .cyc_cnt(cyc_cnt), .mispred_cnt(mispred_cnt), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.MDU_TIMEOUT(4), .CNT_W(4)) dut_wrap (
        .clk(clk), .rst(rst),
        .ex_load_use(ex_load_use), .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
        .im_ready(im_ready), .dm_req(dm_req), .dm_ready(dm_ready),
        .mdu_start(mdu_start), .mdu_done(mdu_done),
        .pc_en(w_pc_en), .pc_sel_redirect(w_pc_sel), .pc_redirect(w_pc_redirect),
        .fd_en(w_fd_en), .de_en(w_de_en), .em_en(w_em_en), .mw_en(w_mw_en),
        .fd_bubble(w_fd_bub), .de_bubble(w_de_bub),
        .mdu_go(w_mdu_go), .mdu_err(w_mdu_err),
        .cyc_cnt(w_cyc_cnt), .mispred_cnt(w_mispred_cnt), .stall_cnt(w_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        ex_load_use = 1'b0; ex_redirect = 1'b0; ex_redirect_pc = 32'h0;
        im_ready = 1'b1; dm_req = 1'b0; dm_ready = 1'b0; mdu_start = 1'b0; mdu_done = 1'b0;
    endtask

    // {pc_en, fd_en, de_en, em_en, mw_en, fd_bubble, de_bubble}
    function automatic logic [31:0] ctl();
        return {25'd0, pc_en, fd_en, de_en, em_en, mw_en, fd_bubble, de_bubble};
    endfunction

    initial begin
        idle();
        ex_redirect_pc = 32'h0000_1234;
        rst = 1'b1;
        tick(); tick();
        settle();
        check("rst_ctl", ctl(), 32'b0000011);
        check("rst_mdu_go", {31'd0, mdu_go}, 32'd0);
        check("rst_mdu_err", {31'd0, mdu_err}, 32'd0);
        check("rst_cyc", cyc_cnt, 32'd0);

        rst = 1'b0;
        settle();
        check("run_ctl", ctl(), 32'b1111100);
        check("run_pc_sel", {31'd0, pc_sel_redirect}, 32'd0);
        check("run_pc_redirect_zero", pc_redirect, 32'd0);

        for (int i = 0; i < 15; i++) tick();
        check("wrap_cyc15", {28'd0, w_cyc_cnt}, 32'd15);
        tick();
        check("wrap_cyc0", {28'd0, w_cyc_cnt}, 32'd0);
        check("cyc16", cyc_cnt, 32'd16);
        check("stall_idle", stall_cnt, 32'd0);

        // data-memory wait: 3 frozen cycles, redirect held from cycle 1
        dm_req = 1'b1; dm_ready = 1'b0;
        settle();
        check("mem_c0_ctl", ctl(), 32'd0);
        tick();
        ex_redirect = 1'b1; ex_redirect_pc = 32'h0000_0200;
        settle();
        check("mem_c1_ctl", ctl(), 32'd0);
        check("mem_c1_sel", {31'd0, pc_sel_redirect}, 32'd0);
        check("mem_c1_pcr", pc_redirect, 32'd0);
        tick();
        settle();
        check("mem_c2_ctl", ctl(), 32'd0);
        check("mem_c2_mispred", mispred_cnt, 32'd0);
        tick();
        dm_ready = 1'b1;
        settle();
        check("mem_c3_ctl", ctl(), 32'b1111111);
        check("mem_c3_sel", {31'd0, pc_sel_redirect}, 32'd1);
        check("mem_c3_pcr", pc_redirect, 32'h0000_0200);
        tick();
        idle();
        settle();
        check("mem_stall_cnt", stall_cnt, 32'd3);
        check("mem_mispred", mispred_cnt, 32'd1);

        // MDU with done on cycle 5
        mdu_start = 1'b1;
        settle();
        check("mdu_c0_go", {31'd0, mdu_go}, 32'd1);
        check("mdu_c0_ctl", ctl(), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            settle();
            check($sformatf("mdu_c%0d_go", c), {31'd0, mdu_go}, 32'd0);
            check($sformatf("mdu_c%0d_ctl", c), ctl(), 32'd0);
        end
        tick();
        mdu_done = 1'b1;
        settle();
        check("mdu_c5_ctl", ctl(), 32'b1111100);
        check("mdu_c5_go", {31'd0, mdu_go}, 32'd0);
        tick();
        idle();
        settle();
        check("mdu_after_ctl", ctl(), 32'b1111100);

        // redirect beats load-use
        m0 = mispred_cnt;
        ex_redirect = 1'b1; ex_load_use = 1'b1; ex_redirect_pc = 32'h0000_0100;
        settle();
        check("redir_sel", {31'd0, pc_sel_redirect}, 32'd1);
        check("redir_pcr", pc_redirect, 32'h0000_0100);
        check("redir_ctl", ctl(), 32'b1111111);
        tick();
        idle();
        settle();
        check("redir_mispred", mispred_cnt, m0 + 32'd1);

        ex_load_use = 1'b1;
        settle();
        check("lu_pc_en", {31'd0, pc_en}, 32'd0);
        check("lu_fd_en", {31'd0, fd_en}, 32'd0);
        check("lu_de_bub", {31'd0, de_bubble}, 32'd1);
        check("lu_em_mw", {30'd0, em_en, mw_en}, 32'd3);
        check("lu_sel", {31'd0, pc_sel_redirect}, 32'd0);
        im_ready = 1'b0;
        settle();
        check("lu_over_im_fd_en", {31'd0, fd_en}, 32'd0);
        check("lu_over_im_fd_bub", {31'd0, fd_bubble}, 32'd0);
        ex_load_use = 1'b0;
        settle();
        check("im_pc_en", {31'd0, pc_en}, 32'd0);
        check("im_fd_bub", {31'd0, fd_bubble}, 32'd1);
        check("im_de_em_mw", {29'd0, de_en, em_en, mw_en}, 32'd7);
        check("im_de_bub", {31'd0, de_bubble}, 32'd0);
        im_ready = 1'b1;
        dm_req = 1'b1; dm_ready = 1'b1;
        settle();
        check("dm_ready_now_ctl", ctl(), 32'b1111100);
        dm_ready = 1'b0; mdu_start = 1'b1;
        settle();
        check("mem_over_mdu_go", {31'd0, mdu_go}, 32'd0);
        check("mem_over_mdu_ctl", ctl(), 32'd0);
        tick();
        dm_ready = 1'b1; mdu_start = 1'b0;
        settle();
        check("mem_release_ctl", ctl(), 32'b1111100);
        tick();
        idle();

        // MDU timeout: 64 frozen cycles, then unfrozen with sticky error
        mdu_start = 1'b1;
        settle();
        check("to_c0_go", {31'd0, mdu_go}, 32'd1);
        frozen_seen = (ctl() == 32'd0) ? 1 : 0;
        for (int c = 1; c <= 63; c++) begin
            tick();
            settle();
            if (ctl() == 32'd0) frozen_seen++;
        end
        check("to_frozen_cycles", frozen_seen, 32'd64);
        tick();
        settle();
        check("to_c64_ctl", ctl(), 32'b1111100);
        check("to_c64_err_pre", {31'd0, mdu_err}, 32'd0);
        tick();
        mdu_start = 1'b0;
        settle();
        check("to_err_set", {31'd0, mdu_err}, 32'd1);
        check("to_run_ctl", ctl(), 32'b1111100);
        for (int c = 0; c < 5; c++) tick();
        check("to_err_sticky", {31'd0, mdu_err}, 32'd1);

        // reset in the middle of an MDU wait
        mdu_start = 1'b1;
        tick(); tick();
        settle();
        check("mid_mdu_frozen", ctl(), 32'd0);
        rst = 1'b1;
        settle();
        check("midrst_err", {31'd0, mdu_err}, 32'd0);
        check("midrst_cyc", cyc_cnt, 32'd0);
        check("midrst_stall", stall_cnt, 32'd0);
        check("midrst_mispred", mispred_cnt, 32'd0);
        check("midrst_ctl", ctl(), 32'b0000011);
        tick();
        mdu_start = 1'b0;
        rst = 1'b0;
        settle();
        check("midrst_run_ctl", ctl(), 32'b1111100);
        tick();
        check("midrst_cyc1", cyc_cnt, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
